// File: rtl/router_pkg.sv
// Shared router definitions: FSM states, address width and header pack/unpack helpers.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int HDR_W     = 8;
    localparam int HDR_LEN_W = HDR_W - ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        PARITY  = 2'd3
    } state_t;

    function automatic logic [HDR_W-1:0] hdr_pack(input logic [HDR_LEN_W-1:0] len,
                                                   input logic [ADDR_W-1:0]    addr);
        return {len, addr};
    endfunction

    function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [HDR_W-1:0] hdr);
        return hdr[HDR_W-1:ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [HDR_W-1:0] hdr);
        return hdr[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/router_pkt_tx.sv
// Router ingress packet generator: IDLE accepts a command, then HEADER, PAYLOAD and
// PARITY stream the packet into the router while honouring busy back-pressure.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 8,
    localparam int LEN_W  = DATA_W - ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_seed,
    input  logic              cmd_corrupt,
    input  logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              pkt_valid,
    output logic              pkt_done,
    output logic              cmd_err,
    output logic [CNT_W-1:0]  sent_count
);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               pkt_valid_q, pkt_valid_d;
    logic               pkt_done_q, pkt_done_d;
    logic               cmd_err_q, cmd_err_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]  seed_q, seed_d;
    logic               corrupt_q, corrupt_d;
    logic [DATA_W-1:0]  parity_q, parity_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            data_out_q  <= '0;
            pkt_valid_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            sent_q      <= '0;
            rem_q       <= '0;
            seed_q      <= '0;
            corrupt_q   <= 1'b0;
            parity_q    <= '0;
        end else begin
            state_q     <= state_d;
            data_out_q  <= data_out_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_done_q  <= pkt_done_d;
            cmd_err_q   <= cmd_err_d;
            sent_q      <= sent_d;
            rem_q       <= rem_d;
            seed_q      <= seed_d;
            corrupt_q   <= corrupt_d;
            parity_q    <= parity_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_out_d  = data_out_q;
        pkt_valid_d = pkt_valid_q;
        pkt_done_d  = 1'b0;
        cmd_err_d   = 1'b0;
        sent_d      = sent_q;
        rem_d       = rem_q;
        seed_d      = seed_q;
        corrupt_d   = corrupt_q;
        parity_d    = parity_q;

        case (state_q)
            IDLE: begin
                data_out_d  = '0;
                pkt_valid_d = 1'b0;
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        state_d     = HEADER;
                        data_out_d  = {cmd_len, cmd_addr};
                        pkt_valid_d = 1'b1;
                        rem_d       = cmd_len;
                        seed_d      = cmd_seed;
                        corrupt_d   = cmd_corrupt;
                    end
                end
            end
            HEADER: begin
                if (!busy) begin
                    state_d    = PAYLOAD;
                    parity_d   = data_out_q;
                    data_out_d = seed_q;
                end
            end
            PAYLOAD: begin
                if (!busy) begin
                    parity_d = parity_q ^ data_out_q;
                    rem_d    = rem_q - LEN_W'(1);
                    // rem_q counts the word on the bus, so 1 means this is the last payload word
                    if (rem_q == LEN_W'(1)) begin
                        state_d     = PARITY;
                        pkt_valid_d = 1'b0;
                        data_out_d  = parity_d ^ {{(DATA_W-1){1'b0}}, corrupt_q};
                    end else begin
                        data_out_d = data_out_q + DATA_W'(1);
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    state_d    = IDLE;
                    data_out_d = '0;
                    pkt_done_d = 1'b1;
                    sent_d     = sent_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                data_out_d  = '0;
                pkt_valid_d = 1'b0;
            end
        endcase
    end

    assign cmd_ready  = (state_q == IDLE);
    assign data_out   = data_out_q;
    assign pkt_valid  = pkt_valid_q;
    assign pkt_done   = pkt_done_q;
    assign cmd_err    = cmd_err_q;
    assign sent_count = sent_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: each task drives one scenario and checks hand-computed words.
module tb_router_pkt_tx;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic [7:0] cmd_seed;
    logic       cmd_corrupt;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       pkt_done;
    logic       cmd_err;
    logic [7:0] sent_count;

    int checks = 0;
    int errors = 0;

    router_pkt_tx #(.DATA_W(8), .CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_seed   (cmd_seed),
        .cmd_corrupt(cmd_corrupt),
        .busy       (busy),
        .data_out   (data_out),
        .pkt_valid  (pkt_valid),
        .pkt_done   (pkt_done),
        .cmd_err    (cmd_err),
        .sent_count (sent_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one command for a single edge; returns 1 ns after the accepting edge.
    task automatic issue(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s,
                         input logic c);
        cmd_valid   = 1'b1;
        cmd_addr    = a;
        cmd_len     = l;
        cmd_seed    = s;
        cmd_corrupt = c;
        step();
        cmd_valid   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++;
        if (data_out !== 8'h00 || pkt_valid !== 1'b0 || pkt_done !== 1'b0 ||
            cmd_err !== 1'b0 || sent_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: data_out=%h pkt_valid=%b pkt_done=%b cmd_err=%b sent=%0d, expected 00/0/0/0/0",
                     data_out, pkt_valid, pkt_done, cmd_err, sent_count);
        end
        reset = 1'b0;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || pkt_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: cmd_ready=%b pkt_valid=%b, expected 1/0", cmd_ready, pkt_valid);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [5];
        logic       exp_v [5];
        exp_d = '{8'h0D, 8'h10, 8'h11, 8'h12, 8'h1E};
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        issue(2'd1, 6'd3, 8'h10, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (data_out !== exp_d[k] || pkt_valid !== exp_v[k]) begin
                errors++;
                $display("FAIL basic_word%0d: data_out=%h pkt_valid=%b, expected %h/%b",
                         k, data_out, pkt_valid, exp_d[k], exp_v[k]);
            end
            checks++;
            if (cmd_ready !== 1'b0 || pkt_done !== 1'b0) begin
                errors++;
                $display("FAIL basic_busyflags%0d: cmd_ready=%b pkt_done=%b, expected 0/0",
                         k, cmd_ready, pkt_done);
            end
            step();
        end
        checks++;
        if (pkt_done !== 1'b1 || sent_count !== 8'd1 || cmd_ready !== 1'b1 ||
            data_out !== 8'h00 || pkt_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: pkt_done=%b sent=%0d cmd_ready=%b data_out=%h pkt_valid=%b, expected 1/1/1/00/0",
                     pkt_done, sent_count, cmd_ready, data_out, pkt_valid);
        end
        step();
        checks++;
        if (pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: pkt_done=%b, expected 0", pkt_done);
        end
    endtask

    task automatic test_busy();
        logic [7:0] exp_d [7];
        logic       exp_v [7];
        exp_d = '{8'h0D, 8'h10, 8'h11, 8'h11, 8'h11, 8'h12, 8'h1E};
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        issue(2'd1, 6'd3, 8'h10, 1'b0);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (data_out !== exp_d[k] || pkt_valid !== exp_v[k]) begin
                errors++;
                $display("FAIL busy_word%0d: data_out=%h pkt_valid=%b, expected %h/%b",
                         k, data_out, pkt_valid, exp_d[k], exp_v[k]);
            end
            busy = (k == 2 || k == 3);
            step();
        end
        busy = 1'b0;
        checks++;
        if (pkt_done !== 1'b1 || sent_count !== 8'd2) begin
            errors++;
            $display("FAIL busy_done: pkt_done=%b sent=%0d, expected 1/2", pkt_done, sent_count);
        end
    endtask

    task automatic test_parity();
        logic [7:0] exp_d [4];
        logic       exp_v [4];
        for (int c = 0; c < 2; c++) begin
            exp_d = '{8'h0A, 8'hFF, 8'h00, (c == 1) ? 8'hF4 : 8'hF5};
            exp_v = '{1'b1, 1'b1, 1'b1, 1'b0};
            issue(2'd2, 6'd2, 8'hFF, (c == 1));
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (data_out !== exp_d[k] || pkt_valid !== exp_v[k]) begin
                    errors++;
                    $display("FAIL parity_c%0d_word%0d: data_out=%h pkt_valid=%b, expected %h/%b",
                             c, k, data_out, pkt_valid, exp_d[k], exp_v[k]);
                end
                step();
            end
            checks++;
            if (pkt_done !== 1'b1 || sent_count !== 8'(3 + c)) begin
                errors++;
                $display("FAIL parity_c%0d_done: pkt_done=%b sent=%0d, expected 1/%0d",
                         c, pkt_done, sent_count, 3 + c);
            end
        end
    endtask

    task automatic test_len0();
        issue(2'd1, 6'd0, 8'h33, 1'b0);
        checks++;
        if (cmd_err !== 1'b1 || pkt_valid !== 1'b0 || data_out !== 8'h00 ||
            cmd_ready !== 1'b1 || sent_count !== 8'd4) begin
            errors++;
            $display("FAIL len0_err: cmd_err=%b pkt_valid=%b data_out=%h cmd_ready=%b sent=%0d, expected 1/0/00/1/4",
                     cmd_err, pkt_valid, data_out, cmd_ready, sent_count);
        end
        step();
        checks++;
        if (cmd_err !== 1'b0 || pkt_valid !== 1'b0 || pkt_done !== 1'b0 || sent_count !== 8'd4) begin
            errors++;
            $display("FAIL len0_after: cmd_err=%b pkt_valid=%b pkt_done=%b sent=%0d, expected 0/0/0/4",
                     cmd_err, pkt_valid, pkt_done, sent_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_d [3];
        logic       exp_v [3];
        issue(2'd2, 6'd4, 8'h40, 1'b0);
        step();
        step();
        checks++;
        if (data_out !== 8'h41 || pkt_valid !== 1'b1) begin
            errors++;
            $display("FAIL resetmid_pre: data_out=%h pkt_valid=%b, expected 41/1", data_out, pkt_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h00 || pkt_valid !== 1'b0 || sent_count !== 8'd0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL resetmid_async: data_out=%h pkt_valid=%b sent=%0d cmd_ready=%b, expected 00/0/0/1",
                     data_out, pkt_valid, sent_count, cmd_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        step();
        exp_d = '{8'h04, 8'h55, 8'h51};
        exp_v = '{1'b1, 1'b1, 1'b0};
        issue(2'd0, 6'd1, 8'h55, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (data_out !== exp_d[k] || pkt_valid !== exp_v[k]) begin
                errors++;
                $display("FAIL resetmid_word%0d: data_out=%h pkt_valid=%b, expected %h/%b",
                         k, data_out, pkt_valid, exp_d[k], exp_v[k]);
            end
            step();
        end
        checks++;
        if (pkt_done !== 1'b1 || sent_count !== 8'd1) begin
            errors++;
            $display("FAIL resetmid_done: pkt_done=%b sent=%0d, expected 1/1", pkt_done, sent_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [4];
        logic       exp_v [4];
        exp_d = '{8'h05, 8'h20, 8'h25, 8'h00};
        exp_v = '{1'b1, 1'b1, 1'b0, 1'b0};
        reset = 1'b1;
        #2;
        reset = 1'b0;
        cmd_valid   = 1'b1;
        cmd_addr    = 2'd1;
        cmd_len     = 6'd1;
        cmd_seed    = 8'h20;
        cmd_corrupt = 1'b0;
        step();
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (data_out !== exp_d[k % 4] || pkt_valid !== exp_v[k % 4] ||
                pkt_done !== (k % 4 == 3)) begin
                errors++;
                $display("FAIL b2b_cycle%0d: data_out=%h pkt_valid=%b pkt_done=%b, expected %h/%b/%b",
                         k, data_out, pkt_valid, pkt_done, exp_d[k % 4], exp_v[k % 4], (k % 4 == 3));
            end
            if (k == 10) cmd_valid = 1'b0;
            step();
        end
        checks++;
        if (sent_count !== 8'd3 || pkt_valid !== 1'b0 || data_out !== 8'h00 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end: sent=%0d pkt_valid=%b data_out=%h cmd_ready=%b, expected 3/0/00/1",
                     sent_count, pkt_valid, data_out, cmd_ready);
        end
    endtask

    initial begin
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_addr    = 2'd0;
        cmd_len     = 6'd0;
        cmd_seed    = 8'h00;
        cmd_corrupt = 1'b0;
        busy        = 1'b0;
        test_reset();
        test_basic();
        test_busy();
        test_parity();
        test_len0();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
